// File: rtl/audio_recorder_pkg.sv
// Shared control package for the audio recorder: address width, FSM state
// encodings and the word-address helper used by the datapath.
package audio_recorder_pkg;

  localparam int ADDR_W = 23;

  typedef logic [ADDR_W-1:0] word_addr_t;

  // Control-state encodings, also exported on o_state for debug.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_SEL = 3'd1;
  localparam logic [2:0] ST_CAPTURE  = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Word address of a sample within a chunk; wraps modulo 2^ADDR_W by design.
  function automatic word_addr_t word_addr(input word_addr_t base, input word_addr_t offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/audio_recorder_sample_sync.sv
// One-entry sample holding register. Holds the word being written to memory
// while the write is outstanding and flags any sample that arrives meanwhile.
module audio_recorder_sample_sync #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  input  logic                load_i,
  input  logic                release_i,
  input  logic                clear_i,
  output logic [SAMPLE_W-1:0] data_o,
  output logic                valid_o,
  output logic                overrun_o
);

  logic [SAMPLE_W-1:0] data_q;
  logic                valid_q;
  logic                overrun_q;

  // Capture the sample on load, free the slot on release, and make the
  // overrun flag sticky until the next recording clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q  <= sample_i;
        valid_q <= 1'b1;
      end else if (release_i) begin
        valid_q <= 1'b0;
      end
      if (clear_i) begin
        overrun_q <= 1'b0;
      end else if (sample_valid_i && valid_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/audio_recorder.sv
// Audio recorder: captures I2S samples into a memory chunk, one word per
// write handshake, under control of start/select/pause/stop levels.
//
// state    | meaning
// IDLE     | waiting for a record request
// WAIT_SEL | request seen, no chunk selected yet
// CAPTURE  | waiting for the next unpaused sample
// WRITE    | word presented to memory, waiting for ack
// DONE     | recording finished, waiting for i_start to fall
module audio_recorder
  import audio_recorder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CHUNK_WORDS = 23'd1048576,
  parameter int                SAMPLE_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_select,
  input  logic                i_pause,
  input  logic                i_stop,
  output logic                o_done,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_valid,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [SAMPLE_W-1:0] o_mem_wdata,
  output logic                o_mem_we,
  input  logic                i_mem_ack,
  output logic [ADDR_W-1:0]   o_length,
  output logic                o_overrun,
  output logic [2:0]          o_state
);

  logic [2:0] state_q, state_d;
  word_addr_t base_q, base_d;
  word_addr_t length_q, length_d;
  word_addr_t addr_q, addr_d;
  word_addr_t length_inc;
  logic       pend_q, pend_d;
  logic       stop_req;
  logic       take_sample;
  logic       release_word;
  logic       clear_flags;
  logic       word_valid;
  logic       overrun;

  // A falling i_start is handled exactly like an explicit stop.
  assign stop_req   = i_stop | ~i_start;
  assign length_inc = length_q + 23'd1;

  audio_recorder_sample_sync #(
    .SAMPLE_W (SAMPLE_W)
  ) u_sample_sync (
    .clk_i          (i_clk),
    .rst_i          (i_rst),
    .sample_i       (i_sample),
    .sample_valid_i (i_sample_valid),
    .load_i         (take_sample),
    .release_i      (release_word),
    .clear_i        (clear_flags),
    .data_o         (o_mem_wdata),
    .valid_o        (word_valid),
    .overrun_o      (overrun)
  );

  // Next-state and datapath control for the recording sequence.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    length_d     = length_q;
    addr_d       = addr_q;
    pend_d       = pend_q;
    take_sample  = 1'b0;
    release_word = 1'b0;
    clear_flags  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          // Length and overrun are cleared even when no chunk is selected yet,
          // so an aborted request reports an empty recording.
          clear_flags = 1'b1;
          length_d    = '0;
          pend_d      = 1'b0;
          if (i_select != '0) begin
            base_d  = i_select;
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_WAIT_SEL;
          end
        end
      end
      ST_WAIT_SEL: begin
        if (stop_req) begin
          state_d = ST_DONE;
        end else if (i_select != '0) begin
          base_d  = i_select;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (stop_req) begin
          state_d = ST_DONE;
        end else if (i_sample_valid && !i_pause) begin
          take_sample = 1'b1;
          addr_d      = word_addr(base_q, length_q);
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (stop_req) begin
          pend_d = 1'b1;
        end
        if (i_mem_ack) begin
          release_word = 1'b1;
          length_d     = length_inc;
          if (length_inc == CHUNK_WORDS || pend_q || stop_req) begin
            pend_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_DONE: begin
        if (!i_start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      length_q <= '0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      length_q <= length_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
    end
  end

  assign o_mem_we   = word_valid;
  assign o_mem_addr = addr_q;
  assign o_length   = length_q;
  assign o_overrun  = overrun;
  assign o_done     = (state_q == ST_DONE);
  assign o_state    = state_q;

endmodule

// File: tb/tb_audio_recorder.sv
// Directed testbench for audio_recorder. Two instances share stimulus: one
// with the default chunk size and one with a 4-word chunk.
module tb_audio_recorder;

  localparam logic [2:0] S_IDLE = 3'd0, S_WSEL = 3'd1, S_CAP = 3'd2, S_WR = 3'd3, S_DONE = 3'd4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [22:0] i_select = '0;
  logic        i_pause = 1'b0;
  logic        i_stop = 1'b0;
  logic [15:0] i_sample = '0;
  logic        i_sample_valid = 1'b0;
  logic        i_mem_ack = 1'b0;

  logic        done, mem_we, overrun;
  logic [22:0] mem_addr, length;
  logic [15:0] mem_wdata;
  logic [2:0]  state;

  logic        done4, mem_we4, overrun4;
  logic [22:0] mem_addr4, length4;
  logic [15:0] mem_wdata4;
  logic [2:0]  state4;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int wr4_cnt = 0;

  audio_recorder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_select(i_select),
    .i_pause(i_pause), .i_stop(i_stop), .o_done(done), .i_sample(i_sample),
    .i_sample_valid(i_sample_valid), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we), .i_mem_ack(i_mem_ack), .o_length(length),
    .o_overrun(overrun), .o_state(state)
  );

  audio_recorder #(.CHUNK_WORDS(23'd4)) dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_select(i_select),
    .i_pause(i_pause), .i_stop(i_stop), .o_done(done4), .i_sample(i_sample),
    .i_sample_valid(i_sample_valid), .o_mem_addr(mem_addr4), .o_mem_wdata(mem_wdata4),
    .o_mem_we(mem_we4), .i_mem_ack(i_mem_ack), .o_length(length4),
    .o_overrun(overrun4), .o_state(state4)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (mem_we && i_mem_ack) wr_cnt <= wr_cnt + 1;
    if (mem_we4 && i_mem_ack) wr4_cnt <= wr4_cnt + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_sample(input logic [15:0] d);
    i_sample = d;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
  endtask

  task automatic ack_word(input int wait_cycles);
    repeat (wait_cycles) tick();
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
  endtask

  task automatic finish_rec();
    i_stop = 1'b0;
    i_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, S_IDLE); end
    checks++; if (mem_we !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags got we=%b done=%b ovr=%b exp 0", mem_we, done, overrun); end
    checks++; if (mem_addr !== 23'h0 || length !== 23'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_data got addr=%h len=%h wdata=%h exp 0", mem_addr, length, mem_wdata); end
    checks++; if (state4 !== S_IDLE || mem_we4 !== 1'b0) begin errors++; $display("FAIL reset_dut4 got st=%0d we=%b exp 0", state4, mem_we4); end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n0;
    n0 = wr_cnt;
    i_select = 23'h000100;
    i_start = 1'b1;
    tick();
    checks++; if (state !== S_CAP || length !== 23'd0) begin errors++; $display("FAIL basic_start got st=%0d len=%0d exp %0d 0", state, length, S_CAP); end
    for (int k = 0; k < 3; k++) begin
      send_sample(16'hA000 + 16'(k));
      checks++; if (mem_we !== 1'b1 || state !== S_WR) begin errors++; $display("FAIL basic_we%0d got we=%b st=%0d exp 1 %0d", k, mem_we, state, S_WR); end
      checks++; if (mem_addr !== 23'h100 + 23'(k) || mem_wdata !== 16'hA000 + 16'(k)) begin errors++; $display("FAIL basic_word%0d got %h/%h exp %h/%h", k, mem_addr, mem_wdata, 23'h100 + 23'(k), 16'hA000 + 16'(k)); end
      tick();
      checks++; if (mem_we !== 1'b1 || mem_addr !== 23'h100 + 23'(k)) begin errors++; $display("FAIL basic_hold%0d got we=%b addr=%h", k, mem_we, mem_addr); end
      ack_word(0);
      checks++; if (mem_we !== 1'b0 || length !== 23'(k + 1) || state !== S_CAP) begin errors++; $display("FAIL basic_ack%0d got we=%b len=%0d st=%0d exp 0 %0d %0d", k, mem_we, length, state, k + 1, S_CAP); end
    end
    i_stop = 1'b1;
    tick();
    checks++; if (state !== S_DONE || done !== 1'b1 || length !== 23'd3) begin errors++; $display("FAIL basic_done got st=%0d done=%b len=%0d exp 4 1 3", state, done, length); end
    checks++; if (wr_cnt - n0 !== 3) begin errors++; $display("FAIL basic_writes got %0d exp 3", wr_cnt - n0); end
    i_stop = 1'b0;
    i_start = 1'b0;
    tick();
    checks++; if (state !== S_IDLE || done !== 1'b0 || length !== 23'd3) begin errors++; $display("FAIL basic_idle got st=%0d done=%b len=%0d exp 0 0 3", state, done, length); end
  endtask

  task automatic test_full_chunk();
    int n0;
    n0 = wr4_cnt;
    i_select = 23'h000040;
    i_start = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      send_sample(16'hB000 + 16'(k));
      if (k < 4) begin
        checks++; if (mem_we4 !== 1'b1 || mem_addr4 !== 23'h40 + 23'(k)) begin errors++; $display("FAIL chunk_word%0d got we=%b addr=%h exp 1 %h", k, mem_we4, mem_addr4, 23'h40 + 23'(k)); end
      end else begin
        checks++; if (mem_we4 !== 1'b0 || state4 !== S_DONE) begin errors++; $display("FAIL chunk_ignore%0d got we=%b st=%0d exp 0 4", k, mem_we4, state4); end
      end
      ack_word(2);
      if (k == 3) begin
        checks++; if (state4 !== S_DONE || done4 !== 1'b1) begin errors++; $display("FAIL chunk_done got st=%0d done=%b exp 4 1", state4, done4); end
      end
    end
    checks++; if (wr4_cnt - n0 !== 4 || length4 !== 23'd4) begin errors++; $display("FAIL chunk_count got writes=%0d len=%0d exp 4 4", wr4_cnt - n0, length4); end
    finish_rec();
    checks++; if (state4 !== S_IDLE) begin errors++; $display("FAIL chunk_idle got %0d exp 0", state4); end
  endtask

  task automatic test_pause();
    i_select = 23'h000300;
    i_start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        i_pause = 1'b1;
        for (int p = 0; p < 3; p++) begin
          send_sample(16'hDEAD);
          checks++; if (mem_we !== 1'b0 || state !== S_CAP) begin errors++; $display("FAIL pause_drop%0d got we=%b st=%0d exp 0 2", p, mem_we, state); end
          tick();
        end
        i_pause = 1'b0;
      end
      send_sample(16'hC000 + 16'(k));
      checks++; if (mem_addr !== 23'h300 + 23'(k) || mem_wdata !== 16'hC000 + 16'(k)) begin errors++; $display("FAIL pause_word%0d got %h/%h exp %h/%h", k, mem_addr, mem_wdata, 23'h300 + 23'(k), 16'hC000 + 16'(k)); end
      ack_word(2);
    end
    checks++; if (length !== 23'd4) begin errors++; $display("FAIL pause_len got %0d exp 4", length); end
    finish_rec();
  endtask

  task automatic test_overrun_stop();
    int n0;
    n0 = wr_cnt;
    i_select = 23'h000500;
    i_start = 1'b1;
    tick();
    send_sample(16'h1111);
    i_sample = 16'h2222;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    checks++; if (overrun !== 1'b1 || mem_wdata !== 16'h1111 || mem_addr !== 23'h500) begin errors++; $display("FAIL ovr_flag got ovr=%b wdata=%h addr=%h exp 1 1111 500", overrun, mem_wdata, mem_addr); end
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    checks++; if (state !== S_WR || mem_we !== 1'b1) begin errors++; $display("FAIL ovr_inflight got st=%0d we=%b exp 3 1", state, mem_we); end
    ack_word(7);
    checks++; if (state !== S_DONE || done !== 1'b1 || length !== 23'd1 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_done got st=%0d done=%b len=%0d ovr=%b exp 4 1 1 1", state, done, length, overrun); end
    checks++; if (wr_cnt - n0 !== 1) begin errors++; $display("FAIL ovr_writes got %0d exp 1", wr_cnt - n0); end
    finish_rec();
  endtask

  task automatic test_wait_sel();
    i_select = 23'h0;
    i_start = 1'b1;
    tick();
    checks++; if (state !== S_WSEL || length !== 23'd0 || overrun !== 1'b0) begin errors++; $display("FAIL wsel_enter got st=%0d len=%0d ovr=%b exp 1 0 0", state, length, overrun); end
    repeat (4) tick();
    i_select = 23'h200000;
    tick();
    checks++; if (state !== S_CAP) begin errors++; $display("FAIL wsel_cap got %0d exp 2", state); end
    send_sample(16'h5A5A);
    checks++; if (mem_addr !== 23'h200000 || mem_we !== 1'b1) begin errors++; $display("FAIL wsel_addr got %h we=%b exp 200000 1", mem_addr, mem_we); end
    ack_word(2);
    finish_rec();
    i_select = 23'h0;
    i_start = 1'b1;
    tick();
    i_stop = 1'b1;
    i_select = 23'h000007;
    tick();
    checks++; if (state !== S_DONE || done !== 1'b1 || length !== 23'd0) begin errors++; $display("FAIL wsel_stop got st=%0d done=%b len=%0d exp 4 1 0", state, done, length); end
    finish_rec();
  endtask

  task automatic test_stop_cases();
    i_select = 23'h000600;
    i_start = 1'b1;
    tick();
    i_sample = 16'h7777;
    i_sample_valid = 1'b1;
    i_stop = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    i_stop = 1'b0;
    checks++; if (state !== S_DONE || mem_we !== 1'b0 || length !== 23'd0) begin errors++; $display("FAIL stopwin got st=%0d we=%b len=%0d exp 4 0 0", state, mem_we, length); end
    finish_rec();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    checks++; if (state !== S_DONE || done !== 1'b1) begin errors++; $display("FAIL startfall_cap got st=%0d done=%b exp 4 1", state, done); end
    tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL startfall_idle got %0d exp 0", state); end
    i_start = 1'b1;
    tick();
    send_sample(16'h3333);
    i_start = 1'b0;
    tick();
    checks++; if (state !== S_WR || mem_we !== 1'b1) begin errors++; $display("FAIL startfall_wr got st=%0d we=%b exp 3 1", state, mem_we); end
    ack_word(1);
    checks++; if (state !== S_DONE || length !== 23'd1) begin errors++; $display("FAIL startfall_done got st=%0d len=%0d exp 4 1", state, length); end
    tick();
  endtask

  task automatic test_wrap();
    i_select = 23'h7FFFFF;
    i_start = 1'b1;
    tick();
    send_sample(16'h0E01);
    checks++; if (mem_addr !== 23'h7FFFFF) begin errors++; $display("FAIL wrap_first got %h exp 7fffff", mem_addr); end
    ack_word(2);
    send_sample(16'h0E02);
    checks++; if (mem_addr !== 23'h000000 || mem_wdata !== 16'h0E02) begin errors++; $display("FAIL wrap_second got %h/%h exp 000000/0e02", mem_addr, mem_wdata); end
    ack_word(2);
    checks++; if (length !== 23'd2) begin errors++; $display("FAIL wrap_len got %0d exp 2", length); end
    finish_rec();
  endtask

  task automatic test_reset_write();
    i_select = 23'h000010;
    i_start = 1'b1;
    tick();
    send_sample(16'h4141);
    ack_word(2);
    send_sample(16'h4242);
    checks++; if (mem_we !== 1'b1 || length !== 23'd1) begin errors++; $display("FAIL rstwr_pre got we=%b len=%0d exp 1 1", mem_we, length); end
    i_start = 1'b0;
    i_rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || state !== S_IDLE || length !== 23'd0) begin errors++; $display("FAIL rstwr_async got we=%b st=%0d len=%0d exp 0 0 0", mem_we, state, length); end
    tick();
    i_rst = 1'b0;
    tick();
    checks++; if (state !== S_IDLE || length !== 23'd0 || mem_we !== 1'b0 || mem_addr !== 23'd0) begin errors++; $display("FAIL rstwr_after got st=%0d len=%0d we=%b addr=%h exp 0", state, length, mem_we, mem_addr); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full_chunk();
    test_pause();
    test_overrun_stop();
    test_wait_sel();
    test_stop_cases();
    test_wrap();
    test_reset_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
